// File: rtl/tt_um_leonoaix_divider.sv
// tt_um_leonoaix_divider: multi-cycle unsigned restoring divider tile.
// ui_in is the 8-bit dividend and uio_in[3:0] is the 4-bit divisor.
// A rising edge on uio_in[4] captures the operands. One quotient bit
// resolves per clock, so a division takes eight cycles.
// uo_out shows the quotient or the remainder, selected live by uio_in[5].
module tt_um_leonoaix_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic [DVD_W-1:0]   dvd_q, dvd_d;    // dividend shifts out at the top, quotient bits shift in at the bottom
  logic [DVD_W-1:0]   dvd_orig_q, dvd_orig_d;
  logic [DVS_W-1:0]   dvs_q, dvs_d;
  logic [DVS_W:0]     r_q, r_d;        // one extra bit so the trial compare cannot overflow
  logic [2:0]         cnt_q, cnt_d;
  logic [DVD_W-1:0]   quo_q, quo_d;
  logic [DVS_W-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               go_s;
  logic [DVS_W:0]     r_sh_s;
  logic [DVS_W:0]     r_new_s;
  logic               qbit_s;

  // ena and the top divisor-port bits carry no function on this tile
  logic unused_s;
  assign unused_s = &{1'b0, ena, uio_in[7:6]};

  assign go_s = uio_in[4] & ~start_q;

  // One restoring iteration: shift in the next dividend bit, then try the subtract
  always_comb begin
    r_sh_s = {r_q[DVS_W-1:0], dvd_q[DVD_W-1]};
    if (r_sh_s >= {1'b0, dvs_q}) begin
      r_new_s = r_sh_s - {1'b0, dvs_q};
      qbit_s  = 1'b1;
    end else begin
      r_new_s = r_sh_s;
      qbit_s  = 1'b0;
    end
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d    = state_q;
    start_d    = uio_in[4];
    dvd_d      = dvd_q;
    dvd_orig_d = dvd_orig_q;
    dvs_d      = dvs_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go_s) begin
          dvd_d      = ui_in;
          dvd_orig_d = ui_in;
          dvs_d      = uio_in[DVS_W-1:0];
          r_d        = '0;
          cnt_d      = 3'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          state_d    = ST_RUN;
        end else begin
          state_d    = state_q;
        end
      end
      ST_RUN: begin
        dvd_d = {dvd_q[DVD_W-2:0], qbit_s};
        r_d   = r_new_s;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Divide by zero is defined as all-ones quotient, low dividend nibble as remainder
          if (dvs_q == '0) begin
            quo_d = 8'hFF;
            rem_d = dvd_orig_q[DVS_W-1:0];
          end else begin
            quo_d = {dvd_q[DVD_W-2:0], qbit_s};
            rem_d = r_new_s[DVS_W-1:0];
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; asynchronous reset aborts any division in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      dvd_q      <= '0;
      dvd_orig_q <= '0;
      dvs_q      <= '0;
      r_q        <= '0;
      cnt_q      <= 3'd0;
      quo_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      dvd_q      <= dvd_d;
      dvd_orig_q <= dvd_orig_d;
      dvs_q      <= dvs_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uo_out  = uio_in[5] ? {4'b0000, rem_q} : quo_q;
  assign uio_out = {done_q, busy_q, 6'b000000};
  assign uio_oe  = 8'hC0;

endmodule

// File: tb/tb_tt_um_leonoaix_divider.sv
// Directed bench for the restoring divider tile with a result scoreboard.
module tb_tt_um_leonoaix_divider;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int vectors;
  int miscompares;
  logic [15:0] sb[$];   // {quotient, 4'b0, remainder}

  tt_um_leonoaix_divider dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [3:0] b);
    if (b == 4'd0) return {8'hFF, 4'h0, a[3:0]};
    else return {a / {4'd0, b}, 8'(a % {4'd0, b})};
  endfunction

  // Drive operands with start high for one capture edge and queue the expected result
  task automatic launch(input logic [7:0] a, input logic [3:0] b, input bit hold);
    ui_in       = a;
    uio_in[3:0] = b;
    uio_in[4]   = 1'b1;
    sb.push_back(model(a, b));
    tick();
    if (!hold) uio_in[4] = 1'b0;
    chk("busy_at_capture", {7'd0, uio_out[6]}, 8'd1);
    chk("done_at_capture", {7'd0, uio_out[7]}, 8'd0);
  endtask

  // Wait (bounded) for done and check how many edges it took
  task automatic wait_done(input string tag, input int exp_edges);
    int n = 0;
    while (uio_out[7] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 8'(n), 8'(exp_edges));
    chk("busy_low_at_done", {7'd0, uio_out[6]}, 8'd0);
  endtask

  // Pop the oldest expected result and compare both views of uo_out
  task automatic check_result(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      uio_in[5] = 1'b0;
      #1;
      chk({tag, "_quo"}, uo_out, e[15:8]);
      uio_in[5] = 1'b1;
      #1;
      chk({tag, "_rem"}, uo_out, e[7:0]);
      uio_in[5] = 1'b0;
      #1;
    end
  endtask

  initial begin
    int busy_rises;
    logic busy_prev;
    vectors     = 0;
    miscompares = 0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    rst_n  = 1'b0;
    #12;
    chk("reset_uo", uo_out, 8'd0);
    chk("reset_uio_out", uio_out, 8'd0);
    chk("uio_oe", uio_oe, 8'hC0);
    rst_n = 1'b1;
    tick();

    // 1: basic division
    launch(8'd200, 4'd7, 1'b0);
    wait_done("lat_200_7", 8);
    check_result("d200_7");

    // 2: boundary operands
    launch(8'd255, 4'd1, 1'b0);
    wait_done("lat_255_1", 8);
    check_result("d255_1");
    launch(8'd3, 4'd9, 1'b0);
    wait_done("lat_3_9", 8);
    check_result("d3_9");
    launch(8'd200, 4'd15, 1'b0);
    wait_done("lat_200_15", 8);
    check_result("d200_15");

    // 3: divide by zero
    launch(8'd5, 4'd0, 1'b0);
    wait_done("lat_div0", 8);
    check_result("d5_0");

    // 4: start held high for 30 cycles launches exactly one operation
    launch(8'd100, 4'd10, 1'b1);
    busy_rises = 0;
    busy_prev  = 1'b1;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (uio_out[6] && !busy_prev) busy_rises++;
      busy_prev = uio_out[6];
    end
    chk("hold_no_relaunch", 8'(busy_rises), 8'd0);
    chk("hold_done", {7'd0, uio_out[7]}, 8'd1);
    uio_in[4] = 1'b0;
    tick();
    check_result("d100_10");
    launch(8'd9, 4'd2, 1'b0);
    wait_done("lat_9_2", 8);
    check_result("d9_2");

    // 5: start pulse during RUN is ignored; previous result visible while running
    launch(8'd77, 4'd6, 1'b0);
    chk("run_shows_prev", uo_out, 8'd4);
    tick();
    ui_in       = 8'd50;
    uio_in[3:0] = 4'd3;
    uio_in[4]   = 1'b1;
    tick();
    uio_in[4]   = 1'b0;
    tick();
    wait_done("lat_ignore_go", 5);
    check_result("d77_6");
    tick();
    chk("no_extra_op", {7'd0, uio_out[6]}, 8'd0);

    // 6: asynchronous reset mid-run
    launch(8'd200, 4'd7, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("arst_uio_out", uio_out, 8'd0);
    chk("arst_uo_quo", uo_out, 8'd0);
    uio_in[5] = 1'b1;
    #1;
    chk("arst_uo_rem", uo_out, 8'd0);
    uio_in[5] = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    launch(8'd123, 4'd11, 1'b0);
    wait_done("lat_after_rst", 8);
    check_result("d123_11");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
